// File: rtl/dmem_pkg.sv
// Shared types and MMIO register map for the data-memory responder.
// Offsets are relative to the MMIO_BASE parameter of the responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RAM_RD,
        TX_WAIT,
        RX_WAIT
    } dmem_state_t;

    typedef enum logic [2:0] {
        RAM,
        RX,
        TX,
        STAT,
        UNMAPPED
    } dmem_region_t;

    localparam logic [31:0] MMIO_RX   = 32'h0000_0000;
    localparam logic [31:0] MMIO_TX   = 32'h0000_0004;
    localparam logic [31:0] MMIO_STAT = 32'h0000_0008;

endpackage

// File: rtl/dmem_decode.sv
// Combinational address decoder: classifies a byte address into a target
// region and flags word-misaligned accesses.
module dmem_decode
    import dmem_pkg::*;
#(
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic [31:0]  data_addr,
    output dmem_region_t region,
    output logic         misaligned
);

    logic [31:0] offset;

    always_comb begin
        offset = data_addr - MMIO_BASE;
        region = RAM;
        if (data_addr >= MMIO_BASE) begin
            case (offset)
                MMIO_RX:   region = RX;
                MMIO_TX:   region = TX;
                MMIO_STAT: region = STAT;
                default:   region = UNMAPPED;
            endcase
        end
    end

    assign misaligned = |data_addr[1:0];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: serves the memory stage from a 1-cycle-latency
// block RAM or the UART MMIO registers, stalling until a response exists.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    input  logic                  we,
    input  logic [31:0]           data_addr,
    input  logic [31:0]           din,
    output logic [31:0]           dout,
    output logic                  stall,
    output logic                  misaligned,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_din,
    input  logic [31:0]           ram_dout,
    output logic [7:0]            uart_tx_data,
    output logic                  uart_tx_valid,
    input  logic                  uart_tx_ready,
    input  logic [7:0]            uart_rx_data,
    input  logic                  uart_rx_valid,
    output logic                  uart_rx_ready
);

    dmem_state_t  state, state_next;
    dmem_region_t region;
    logic         addr_misaligned;
    logic [7:0]   tx_byte;
    logic         tx_latch;
    logic         mis_flag;
    logic         mis_set;

    logic [31:0]  dout_c;
    logic         stall_c, ram_en_c, ram_we_c;
    logic         tx_valid_c, rx_ready_c;
    logic [7:0]   tx_data_c;

    dmem_decode #(
        .MMIO_BASE(MMIO_BASE)
    ) u_decode (
        .data_addr (data_addr),
        .region    (region),
        .misaligned(addr_misaligned)
    );

    always_comb begin
        state_next = state;
        dout_c     = '0;
        stall_c    = 1'b0;
        ram_en_c   = 1'b0;
        ram_we_c   = 1'b0;
        tx_valid_c = 1'b0;
        tx_data_c  = '0;
        rx_ready_c = 1'b0;
        tx_latch   = 1'b0;
        mis_set    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (addr_misaligned) begin
                        mis_set = 1'b1;
                    end else begin
                        case (region)
                            RAM: begin
                                ram_en_c = 1'b1;
                                if (we) begin
                                    ram_we_c = 1'b1;
                                end else begin
                                    stall_c    = 1'b1;
                                    state_next = RAM_RD;
                                end
                            end
                            TX: begin
                                if (we) begin
                                    tx_valid_c = 1'b1;
                                    tx_data_c  = din[7:0];
                                    if (!uart_tx_ready) begin
                                        stall_c    = 1'b1;
                                        tx_latch   = 1'b1;
                                        state_next = TX_WAIT;
                                    end
                                end
                            end
                            RX: begin
                                if (!we) begin
                                    if (uart_rx_valid) begin
                                        rx_ready_c = 1'b1;
                                        dout_c     = {24'b0, uart_rx_data};
                                    end else begin
                                        stall_c    = 1'b1;
                                        state_next = RX_WAIT;
                                    end
                                end
                            end
                            STAT: begin
                                if (!we) dout_c = {30'b0, uart_rx_valid, uart_tx_ready};
                            end
                            default: ;
                        endcase
                    end
                end
            end
            // The request is still held here; the RAM is not re-enabled.
            RAM_RD: begin
                dout_c     = ram_dout;
                state_next = IDLE;
            end
            TX_WAIT: begin
                tx_valid_c = 1'b1;
                tx_data_c  = tx_byte;
                if (uart_tx_ready) state_next = IDLE;
                else               stall_c    = 1'b1;
            end
            RX_WAIT: begin
                if (uart_rx_valid) begin
                    rx_ready_c = 1'b1;
                    dout_c     = {24'b0, uart_rx_data};
                    state_next = IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            tx_byte  <= '0;
            mis_flag <= 1'b0;
        end else begin
            state <= state_next;
            if (tx_latch) tx_byte  <= din[7:0];
            if (mis_set)  mis_flag <= 1'b1;
        end
    end

    // Outputs are forced low while reset is asserted, even with a request held.
    assign dout          = rstn ? dout_c : '0;
    assign stall         = rstn & stall_c;
    assign misaligned    = mis_flag;
    assign ram_en        = rstn & ram_en_c;
    assign ram_we        = rstn & ram_we_c;
    assign ram_addr      = rstn ? data_addr[ADDR_WIDTH+1:2] : '0;
    assign ram_din       = rstn ? din : '0;
    assign uart_tx_data  = rstn ? tx_data_c : '0;
    assign uart_tx_valid = rstn & tx_valid_c;
    assign uart_rx_ready = rstn & rx_ready_c;

endmodule
